// File: rtl/tl_mem_responder.sv
// Single-transaction TileLink memory responder backed by a 2^BLOCKS_LOG2 x 4-beat x 128-bit array.
// Define TL_MEM_RESP_DELAY_EN to hold acquire grants in WAIT for LATENCY cycles.
module tl_mem_responder #(
  parameter int BLOCKS_LOG2 = 6,
  parameter int LATENCY     = 4
) (
  input  logic         clk,
  input  logic         reset,
  output logic         acquire_ready,
  input  logic         acquire_valid,
  input  logic [25:0]  acquire_bits_addr_block,
  input  logic [1:0]   acquire_bits_client_xact_id,
  input  logic [1:0]   acquire_bits_addr_beat,
  input  logic         acquire_bits_is_builtin_type,
  input  logic [2:0]   acquire_bits_a_type,
  input  logic [16:0]  acquire_bits_union,
  input  logic [127:0] acquire_bits_data,
  input  logic         grant_ready,
  output logic         grant_valid,
  output logic [1:0]   grant_bits_addr_beat,
  output logic [1:0]   grant_bits_client_xact_id,
  output logic [3:0]   grant_bits_manager_xact_id,
  output logic         grant_bits_is_builtin_type,
  output logic [3:0]   grant_bits_g_type,
  output logic [127:0] grant_bits_data,
  input  logic         probe_ready,
  output logic         probe_valid,
  output logic         release_ready,
  input  logic         release_valid,
  input  logic [1:0]   release_bits_addr_beat,
  input  logic [25:0]  release_bits_addr_block,
  input  logic [1:0]   release_bits_client_xact_id,
  input  logic         release_bits_voluntary,
  input  logic [2:0]   release_bits_r_type,
  input  logic [127:0] release_bits_data
);

  localparam int AW    = BLOCKS_LOG2 + 2;
  localparam int DEPTH = 1 << AW;
  localparam logic [2:0] A_GET_BLOCK = 3'd1;
  localparam logic [2:0] A_PUT_BLOCK = 3'd3;

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_range
    $error("tl_mem_responder: LATENCY must be within 1..15");
  end

  typedef enum logic [2:0] {
    IDLE,
    PUT_DATA,
    WAIT,
    GRANT_DATA,
    GRANT_ACK,
    REL_DATA
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             beat_q, beat_d;
  logic [BLOCKS_LOG2-1:0] block_q, block_d;
  logic [1:0]             xact_q, xact_d;
  logic                   builtin_q, builtin_d;
  logic [2:0]             a_type_q, a_type_d;
  logic                   voluntary_q, voluntary_d;
  logic                   from_release_q, from_release_d;
  logic [3:0]             mgr_q, mgr_d;
`ifdef TL_MEM_RESP_DELAY_EN
  logic [3:0]             wait_cnt_q, wait_cnt_d;
  logic                   wait_data_q, wait_data_d;
`endif

  logic [127:0]           mem_q [DEPTH];
  logic                   mem_we;
  logic [AW-1:0]          mem_waddr;
  logic [127:0]           mem_wdata;

  logic acquire_fire, release_fire, grant_fire;
  logic go_data, go_ack;

  assign release_ready = (state_q == IDLE) || (state_q == REL_DATA);
  assign acquire_ready = ((state_q == IDLE) && !release_valid) || (state_q == PUT_DATA);
  assign grant_valid   = (state_q == GRANT_DATA) || (state_q == GRANT_ACK);
  assign probe_valid   = 1'b0;

  assign acquire_fire = acquire_valid && acquire_ready;
  assign release_fire = release_valid && release_ready;
  assign grant_fire   = grant_valid && grant_ready;

  logic unused_inputs;
  assign unused_inputs = ^{acquire_bits_union, probe_ready, release_bits_r_type,
                           acquire_bits_addr_block[25:BLOCKS_LOG2],
                           release_bits_addr_block[25:BLOCKS_LOG2]};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    block_d        = block_q;
    xact_d         = xact_q;
    builtin_d      = builtin_q;
    a_type_d       = a_type_q;
    voluntary_d    = voluntary_q;
    from_release_d = from_release_q;
    mgr_d          = mgr_q;
`ifdef TL_MEM_RESP_DELAY_EN
    wait_cnt_d     = wait_cnt_q;
    wait_data_d    = wait_data_q;
`endif
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    go_data   = 1'b0;
    go_ack    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (release_fire) begin
          mem_we         = 1'b1;
          mem_waddr      = {release_bits_addr_block[BLOCKS_LOG2-1:0], release_bits_addr_beat};
          mem_wdata      = release_bits_data;
          block_d        = release_bits_addr_block[BLOCKS_LOG2-1:0];
          xact_d         = release_bits_client_xact_id;
          voluntary_d    = release_bits_voluntary;
          from_release_d = 1'b1;
          beat_d         = 2'd1;
          state_d        = REL_DATA;
        end else if (acquire_fire) begin
          block_d        = acquire_bits_addr_block[BLOCKS_LOG2-1:0];
          xact_d         = acquire_bits_client_xact_id;
          builtin_d      = acquire_bits_is_builtin_type;
          a_type_d       = acquire_bits_a_type;
          from_release_d = 1'b0;
          if (acquire_bits_is_builtin_type && acquire_bits_a_type == A_PUT_BLOCK) begin
            mem_we    = 1'b1;
            mem_waddr = {acquire_bits_addr_block[BLOCKS_LOG2-1:0], acquire_bits_addr_beat};
            mem_wdata = acquire_bits_data;
            beat_d    = 2'd1;
            state_d   = PUT_DATA;
          end else if (!acquire_bits_is_builtin_type || acquire_bits_a_type == A_GET_BLOCK) begin
            go_data = 1'b1;
          end else begin
            go_ack = 1'b1;
          end
        end
      end
      PUT_DATA: begin
        if (acquire_fire) begin
          mem_we    = 1'b1;
          mem_waddr = {block_q, acquire_bits_addr_beat};
          mem_wdata = acquire_bits_data;
          beat_d    = beat_q + 2'd1;
          go_ack    = (beat_q == 2'd3);
        end
      end
      REL_DATA: begin
        if (release_fire) begin
          mem_we    = 1'b1;
          mem_waddr = {block_q, release_bits_addr_beat};
          mem_wdata = release_bits_data;
          beat_d    = beat_q + 2'd1;
          // Voluntary writebacks are acknowledged at once; probe responses are not.
          if (beat_q == 2'd3) state_d = voluntary_q ? GRANT_ACK : IDLE;
        end
      end
      WAIT: begin
`ifdef TL_MEM_RESP_DELAY_EN
        if (wait_cnt_q == 4'd0) state_d = wait_data_q ? GRANT_DATA : GRANT_ACK;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
`else
        state_d = IDLE;
`endif
      end
      GRANT_DATA: begin
        if (grant_fire) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            mgr_d   = mgr_q + 4'd1;
            state_d = IDLE;
          end
        end
      end
      GRANT_ACK: begin
        if (grant_fire) begin
          mgr_d   = mgr_q + 4'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_data || go_ack) begin
      beat_d = 2'd0;
`ifdef TL_MEM_RESP_DELAY_EN
      // The load of LATENCY-1 plus the zero-count exit cycle gives LATENCY cycles in WAIT.
      state_d     = WAIT;
      wait_cnt_d  = 4'(LATENCY - 1);
      wait_data_d = go_data;
`else
      state_d = go_data ? GRANT_DATA : GRANT_ACK;
`endif
    end
  end

  always_comb begin
    grant_bits_addr_beat       = 2'd0;
    grant_bits_client_xact_id  = 2'd0;
    grant_bits_manager_xact_id = 4'd0;
    grant_bits_is_builtin_type = 1'b0;
    grant_bits_g_type          = 4'd0;
    grant_bits_data            = '0;
    if (state_q == GRANT_DATA) begin
      grant_bits_addr_beat       = beat_q;
      grant_bits_client_xact_id  = xact_q;
      grant_bits_manager_xact_id = mgr_q;
      grant_bits_is_builtin_type = builtin_q;
      grant_bits_g_type          = (a_type_q == A_GET_BLOCK) ? 4'd1 : 4'd0;
      grant_bits_data            = mem_q[{block_q, beat_q}];
    end else if (state_q == GRANT_ACK) begin
      grant_bits_client_xact_id  = xact_q;
      grant_bits_manager_xact_id = mgr_q;
      grant_bits_is_builtin_type = 1'b1;
      grant_bits_g_type          = from_release_q ? 4'd0 : 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      beat_q         <= 2'd0;
      block_q        <= '0;
      xact_q         <= 2'd0;
      builtin_q      <= 1'b0;
      a_type_q       <= 3'd0;
      voluntary_q    <= 1'b0;
      from_release_q <= 1'b0;
      mgr_q          <= 4'd0;
`ifdef TL_MEM_RESP_DELAY_EN
      wait_cnt_q     <= 4'd0;
      wait_data_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      block_q        <= block_d;
      xact_q         <= xact_d;
      builtin_q      <= builtin_d;
      a_type_q       <= a_type_d;
      voluntary_q    <= voluntary_d;
      from_release_q <= from_release_d;
      mgr_q          <= mgr_d;
`ifdef TL_MEM_RESP_DELAY_EN
      wait_cnt_q     <= wait_cnt_d;
      wait_data_q    <= wait_data_d;
`endif
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM; partial writes survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_tl_mem_responder.sv
// Directed self-checking bench for tl_mem_responder; expected values are hand-derived.
module tb_tl_mem_responder;

  localparam int LAT = 4;
`ifdef TL_MEM_RESP_DELAY_EN
  localparam int EXP_LAT = LAT + 1;
`else
  localparam int EXP_LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         acquire_ready, acquire_valid;
  logic [25:0]  acquire_bits_addr_block;
  logic [1:0]   acquire_bits_client_xact_id, acquire_bits_addr_beat;
  logic         acquire_bits_is_builtin_type;
  logic [2:0]   acquire_bits_a_type;
  logic [16:0]  acquire_bits_union;
  logic [127:0] acquire_bits_data;
  logic         grant_ready, grant_valid;
  logic [1:0]   grant_bits_addr_beat, grant_bits_client_xact_id;
  logic [3:0]   grant_bits_manager_xact_id, grant_bits_g_type;
  logic         grant_bits_is_builtin_type;
  logic [127:0] grant_bits_data;
  logic         probe_ready, probe_valid;
  logic         release_ready, release_valid;
  logic [1:0]   release_bits_addr_beat, release_bits_client_xact_id;
  logic [25:0]  release_bits_addr_block;
  logic         release_bits_voluntary;
  logic [2:0]   release_bits_r_type;
  logic [127:0] release_bits_data;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  tl_mem_responder #(.BLOCKS_LOG2(6), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .acquire_ready(acquire_ready), .acquire_valid(acquire_valid),
    .acquire_bits_addr_block(acquire_bits_addr_block),
    .acquire_bits_client_xact_id(acquire_bits_client_xact_id),
    .acquire_bits_addr_beat(acquire_bits_addr_beat),
    .acquire_bits_is_builtin_type(acquire_bits_is_builtin_type),
    .acquire_bits_a_type(acquire_bits_a_type),
    .acquire_bits_union(acquire_bits_union),
    .acquire_bits_data(acquire_bits_data),
    .grant_ready(grant_ready), .grant_valid(grant_valid),
    .grant_bits_addr_beat(grant_bits_addr_beat),
    .grant_bits_client_xact_id(grant_bits_client_xact_id),
    .grant_bits_manager_xact_id(grant_bits_manager_xact_id),
    .grant_bits_is_builtin_type(grant_bits_is_builtin_type),
    .grant_bits_g_type(grant_bits_g_type),
    .grant_bits_data(grant_bits_data),
    .probe_ready(probe_ready), .probe_valid(probe_valid),
    .release_ready(release_ready), .release_valid(release_valid),
    .release_bits_addr_beat(release_bits_addr_beat),
    .release_bits_addr_block(release_bits_addr_block),
    .release_bits_client_xact_id(release_bits_client_xact_id),
    .release_bits_voluntary(release_bits_voluntary),
    .release_bits_r_type(release_bits_r_type),
    .release_bits_data(release_bits_data)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] dval(input int seed, input int b);
    return {32'(seed), 32'(b), 32'hC0DE0000 ^ 32'(seed * 97 + b), 32'hFFFFFFFF ^ 32'(b * 13 + seed)};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int cycles);
    cycles = 1;
    while (!grant_valid && cycles < 64) begin
      tick();
      cycles++;
    end
    check("grant_timeout", 128'(grant_valid), 128'd1);
  endtask

  task automatic do_acquire(input logic [25:0] blk, input logic [1:0] xact, input logic builtin,
                            input logic [2:0] atype, input logic [1:0] beat, input logic [127:0] data);
    acquire_valid                = 1'b1;
    acquire_bits_addr_block      = blk;
    acquire_bits_client_xact_id  = xact;
    acquire_bits_is_builtin_type = builtin;
    acquire_bits_a_type          = atype;
    acquire_bits_addr_beat       = beat;
    acquire_bits_data            = data;
    #1 check("acq_ready", 128'(acquire_ready), 128'd1);
    tick();
    acquire_valid = 1'b0;
  endtask

  task automatic send_release(input logic [25:0] blk, input logic [1:0] xact, input logic vol, input int seed);
    for (int b = 0; b < 4; b++) begin
      release_valid               = 1'b1;
      release_bits_addr_block     = blk;
      release_bits_client_xact_id = xact;
      release_bits_voluntary      = vol;
      release_bits_addr_beat      = 2'(b);
      release_bits_data           = dval(seed, b);
      #1 check("rel_ready", 128'(release_ready), 128'd1);
      tick();
    end
    release_valid = 1'b0;
  endtask

  task automatic check_burst(input string tag, input logic [1:0] xact, input logic [3:0] mgr,
                             input logic builtin, input logic [3:0] gtype, input int seed);
    int c;
    wait_grant(c);
    for (int b = 0; b < 4; b++) begin
      check({tag, "_beat"},    128'(grant_bits_addr_beat), 128'(b));
      check({tag, "_data"},    grant_bits_data, dval(seed, b));
      check({tag, "_gtype"},   128'(grant_bits_g_type), 128'(gtype));
      check({tag, "_builtin"}, 128'(grant_bits_is_builtin_type), 128'(builtin));
      check({tag, "_xact"},    128'(grant_bits_client_xact_id), 128'(xact));
      check({tag, "_mgr"},     128'(grant_bits_manager_xact_id), 128'(mgr));
      tick();
    end
    check({tag, "_done"}, 128'(grant_valid), 128'd0);
  endtask

  task automatic check_ack(input string tag, input logic [1:0] xact, input logic [3:0] mgr, input logic [3:0] gtype);
    check({tag, "_valid"},   128'(grant_valid), 128'd1);
    check({tag, "_gtype"},   128'(grant_bits_g_type), 128'(gtype));
    check({tag, "_builtin"}, 128'(grant_bits_is_builtin_type), 128'd1);
    check({tag, "_beat"},    128'(grant_bits_addr_beat), 128'd0);
    check({tag, "_data"},    grant_bits_data, 128'd0);
    check({tag, "_xact"},    128'(grant_bits_client_xact_id), 128'(xact));
    check({tag, "_mgr"},     128'(grant_bits_manager_xact_id), 128'(mgr));
  endtask

  initial begin
    reset = 1'b1;
    acquire_valid = 1'b0; acquire_bits_addr_block = '0; acquire_bits_client_xact_id = '0;
    acquire_bits_addr_beat = '0; acquire_bits_is_builtin_type = 1'b0; acquire_bits_a_type = '0;
    acquire_bits_union = 17'h1ABCD; acquire_bits_data = '0;
    grant_ready = 1'b1; probe_ready = 1'b1;
    release_valid = 1'b0; release_bits_addr_beat = '0; release_bits_addr_block = '0;
    release_bits_client_xact_id = '0; release_bits_voluntary = 1'b0; release_bits_r_type = 3'd5;
    release_bits_data = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_grant_valid", 128'(grant_valid), 128'd0);
    check("rst_grant_data",  grant_bits_data, 128'd0);
    check("rst_grant_mgr",   128'(grant_bits_manager_xact_id), 128'd0);
    check("rst_grant_gtype", 128'(grant_bits_g_type), 128'd0);
    check("rst_acq_ready",   128'(acquire_ready), 128'd1);
    check("rst_rel_ready",   128'(release_ready), 128'd1);
    check("rst_probe_valid", 128'(probe_valid), 128'd0);

    // Release and cached acquire arrive together; the release wins.
    release_valid = 1'b1; release_bits_addr_block = 26'h5; release_bits_client_xact_id = 2'd2;
    release_bits_voluntary = 1'b1; release_bits_addr_beat = 2'd0; release_bits_data = dval(1, 0);
    acquire_valid = 1'b1; acquire_bits_addr_block = 26'h5; acquire_bits_client_xact_id = 2'd1;
    acquire_bits_is_builtin_type = 1'b0; acquire_bits_a_type = 3'd1;
    #1;
    check("collide_acq_ready", 128'(acquire_ready), 128'd0);
    check("collide_rel_ready", 128'(release_ready), 128'd1);
    for (int b = 0; b < 4; b++) begin
      release_bits_addr_beat = 2'(b);
      release_bits_data      = dval(1, b);
      #1 check("acq_blocked_by_rel", 128'(acquire_ready), 128'd0);
      tick();
    end
    release_valid = 1'b0;
    #1;
    check_ack("rel_ack", 2'd2, 4'd0, 4'd0);
    check("rel_ack_acq_ready", 128'(acquire_ready), 128'd0);
    tick();
    check("rel_ack_done", 128'(grant_valid), 128'd0);
    check("idle_acq_ready",  128'(acquire_ready), 128'd1);
    tick();
    acquire_valid = 1'b0;
    check_burst("cached_get", 2'd1, 4'd1, 1'b0, 4'd1, 1);

    // PutBlock with upper address bits set, then GetBlock of the same low index.
    for (int b = 0; b < 4; b++) do_acquire(26'h100003C, 2'd2, 1'b1, 3'd3, 2'(b), dval(2, b));
    wait_grant(lat);
    check("put_latency", 128'(lat), 128'(EXP_LAT));
    check_ack("put_ack", 2'd2, 4'd2, 4'd3);
    tick();
    check("put_ack_done", 128'(grant_valid), 128'd0);
    do_acquire(26'h3C, 2'd0, 1'b1, 3'd1, 2'd0, '0);
    wait_grant(lat);
    check("get_latency", 128'(lat), 128'(EXP_LAT));
    check_burst("get_3c", 2'd0, 4'd3, 1'b1, 4'd1, 2);

    // Back-pressure at beat 2.
    do_acquire(26'h5, 2'd3, 1'b1, 3'd1, 2'd0, '0);
    wait_grant(lat);
    check("stall_beat0", 128'(grant_bits_addr_beat), 128'd0);
    tick();
    check("stall_beat1", 128'(grant_bits_addr_beat), 128'd1);
    tick();
    grant_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_hold_beat", 128'(grant_bits_addr_beat), 128'd2);
      check("stall_hold_data", grant_bits_data, dval(1, 2));
      check("stall_hold_valid", 128'(grant_valid), 128'd1);
      tick();
    end
    check("stall_resume_beat", 128'(grant_bits_addr_beat), 128'd2);
    grant_ready = 1'b1;
    tick();
    check("stall_beat3", 128'(grant_bits_addr_beat), 128'd3);
    check("stall_data3", grant_bits_data, dval(1, 3));
    tick();
    check("stall_done", 128'(grant_valid), 128'd0);

    // Built-in acquire of another type: acknowledge only.
    do_acquire(26'h7, 2'd1, 1'b1, 3'd2, 2'd0, '0);
    wait_grant(lat);
    check_ack("other_ack", 2'd1, 4'd5, 4'd3);
    tick();
    check("other_ack_done", 128'(grant_valid), 128'd0);

    // Non-voluntary release produces no grant.
    send_release(26'h9, 2'd0, 1'b0, 3);
    #1;
    check("nonvol_no_grant", 128'(grant_valid), 128'd0);
    check("nonvol_acq_ready", 128'(acquire_ready), 128'd1);

    // Reset in the middle of a data grant.
    do_acquire(26'h3C, 2'd1, 1'b1, 3'd1, 2'd0, '0);
    wait_grant(lat);
    check("mid_rst_pre_mgr", 128'(grant_bits_manager_xact_id), 128'd6);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 128'(grant_valid), 128'd0);
    check("mid_rst_data",  grant_bits_data, 128'd0);
    check("mid_rst_mgr",   128'(grant_bits_manager_xact_id), 128'd0);
    check("mid_rst_acq_ready", 128'(acquire_ready), 128'd1);
    reset = 1'b0;

    // Array survives reset; 17 consecutive Gets wrap the manager id.
    for (int i = 0; i < 17; i++) begin
      do_acquire(26'h3C, 2'(i), 1'b1, 3'd1, 2'd0, '0);
      check_burst("get_seq", 2'(i), 4'(i), 1'b1, 4'd1, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
